// File: rtl/data_mem_responder_if.sv
// Load/store bus between the CPU control path and data_mem_responder.
// The master drives the request; the slave returns busy, ready, error and data.
interface data_mem_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memBusy;
  logic        memReady;
  logic        memErr;

  modport master (
    output memRead, memWrite, memAddr, memWriteData,
    input  memReadData, memBusy, memReady, memErr
  );

  modport slave (
    input  memRead, memWrite, memAddr, memWriteData,
    output memReadData, memBusy, memReady, memErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-stated word memory responder for CPU loads/stores: one access at a time,
// one-cycle memReady pulse with memErr. Define MEM_ALIGN_CHECK_EN to reject unaligned addresses.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] LIMIT     = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_busy;
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic [31:0]   w_offset;
  logic          w_addr_err;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_we;

  // Below-base is tested on the raw address so a wrapped offset can never look in range.
  assign w_offset = r_addr - BASE_ADDR;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_addr_err = (r_addr < BASE_ADDR) || ({1'b0, w_offset} >= LIMIT) || (r_addr[1:0] != 2'b00);
`else
  assign w_addr_err = (r_addr < BASE_ADDR) || ({1'b0, w_offset} >= LIMIT);
`endif
  assign w_err = (r_rd & r_wr) | w_addr_err;
  assign w_idx = w_offset[AW+1:2];
  assign w_we  = (r_state == S_ACCESS) && !rst && r_wr && !w_err;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.memRead || bus.memWrite) begin
            r_rd    <= bus.memRead;
            r_wr    <= bus.memWrite;
            r_addr  <= bus.memAddr;
            r_wdata <= bus.memWriteData;
            r_busy  <= 1'b1;
            r_cnt   <= WAIT_INIT;
            r_state <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_ACCESS;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          if (r_rd && !w_err) r_rdata <= r_mem[w_idx];
          r_ready <= 1'b1;
          r_err   <= w_err;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.memReadData = r_rdata;
  assign bus.memBusy     = r_busy;
  assign bus.memReady    = r_ready;
  assign bus.memErr      = r_err;

endmodule
